atmospheric_light_estimator: RTL and testbench

Streaming stage directly upstream of the atmospheric-light reciprocal lookup. Per frame, finds the haziest pixel: maximum dark channel min(R,G,B), ties broken by larger R+G+B. At end of frame, publishes that pixel's R, G and B as the per-channel atmospheric light A_R, A_G, A_B, each clamped to 1..255 so the reciprocal lookup never sees 0. The held outputs feed the reciprocal lookup and the transmission stage for the next frame.

---
 rtl/dehaze_pkg.sv | 31 +++
 rtl/atmospheric_light_estimator_if.sv | 29 ++
 rtl/dark_channel_min3.sv | 17 +
 rtl/atmospheric_light_estimator.sv | 157 +++++++++++++++
 tb/tb_atmospheric_light_estimator.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/dehaze_pkg.sv
// Shared types and constants for the dehaze pipeline stages.
// Pixel width, atmospheric-light reset value, candidate record and zero-clamp helper.
package dehaze_pkg;

    localparam int PIX_W = 8;
    localparam int SUM_W = PIX_W + 2;
    localparam logic [PIX_W-1:0] AC_RST = 8'd255;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [SUM_W-1:0] sum_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // One haze candidate: ranking keys first, then the colour it carries.
    typedef struct packed {
        pix_t dark;
        sum_t sum;
        pix_t r;
        pix_t g;
        pix_t b;
    } cand_t;

    // The downstream reciprocal lookup cannot take 0, so 0 maps to 1.
    function automatic pix_t clamp_nz(input pix_t v);
        return (v == '0) ? pix_t'(1) : v;
    endfunction

endpackage

// File: rtl/atmospheric_light_estimator_if.sv
// Pixel stream in, per-frame atmospheric light out; master drives pixels, slave is the estimator.
// No backpressure: the slave accepts a pixel on every cycle in_valid is high.
interface atmospheric_light_estimator_if;
    import dehaze_pkg::*;

    logic in_valid;
    logic in_sof;
    logic in_eof;
    pix_t in_r;
    pix_t in_g;
    pix_t in_b;

    pix_t ac_r;
    pix_t ac_g;
    pix_t ac_b;
    logic ac_valid;
    logic frame_err;

    modport master (
        output in_valid, in_sof, in_eof, in_r, in_g, in_b,
        input  ac_r, ac_g, ac_b, ac_valid, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_eof, in_r, in_g, in_b,
        output ac_r, ac_g, ac_b, ac_valid, frame_err
    );

endinterface

// File: rtl/dark_channel_min3.sv
// Combinational minimum of three colour channels (the dark channel of one pixel).
// Zero latency, no handshake.
module dark_channel_min3
    import dehaze_pkg::*;
(
    input  pix_t a_i,
    input  pix_t b_i,
    input  pix_t c_i,
    output pix_t min_o
);

    pix_t ab_min;

    assign ab_min = (a_i < b_i) ? a_i : b_i;
    assign min_o  = (ab_min < c_i) ? ab_min : c_i;

endmodule

// File: rtl/atmospheric_light_estimator.sv
// Per frame, tracks the pixel with the largest dark channel (ties: larger R+G+B) and publishes its clamped RGB.
// eof sampled at edge N -> ac_* and ac_valid after edge N+2; always accepts, no backpressure.
module atmospheric_light_estimator
    import dehaze_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    atmospheric_light_estimator_if.slave bus
);

    // Stage 1: dark channel, channel sum and frame flags.
    pix_t  dark_w;
    sum_t  sum_w;

    logic  s1_vld_q;
    logic  s1_sof_q;
    logic  s1_eof_q;
    cand_t s1_cand_q;

    dark_channel_min3 u_min3 (
        .a_i   (bus.in_r),
        .b_i   (bus.in_g),
        .c_i   (bus.in_b),
        .min_o (dark_w)
    );

    assign sum_w = SUM_W'(bus.in_r) + SUM_W'(bus.in_g) + SUM_W'(bus.in_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_eof_q  <= 1'b0;
            s1_cand_q <= '0;
        end else begin
            s1_vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sof_q  <= bus.in_sof;
                s1_eof_q  <= bus.in_eof;
                s1_cand_q <= '{dark: dark_w, sum: sum_w,
                               r: bus.in_r, g: bus.in_g, b: bus.in_b};
            end
        end
    end

    // Frame FSM, driven by the stage-1 flags.
    state_t state_q;
    state_t state_d;
    logic   load_best;
    logic   cmp_best;
    logic   pub_d;
    logic   frame_err_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (s1_vld_q) begin
            case (state_q)
                IDLE:    if (s1_sof_q && !s1_eof_q) state_d = ACCUM;
                ACCUM:   if (s1_eof_q)              state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A sof inside a frame restarts accumulation; an sof+eof pixel is a complete frame either way.
    always_comb begin
        load_best   = 1'b0;
        cmp_best    = 1'b0;
        pub_d       = 1'b0;
        frame_err_w = 1'b0;
        if (s1_vld_q) begin
            case (state_q)
                IDLE: begin
                    if (s1_sof_q) begin
                        load_best = 1'b1;
                        pub_d     = s1_eof_q;
                    end else begin
                        frame_err_w = 1'b1;
                    end
                end
                ACCUM: begin
                    if (s1_sof_q) begin
                        frame_err_w = 1'b1;
                        load_best   = 1'b1;
                    end else begin
                        cmp_best = 1'b1;
                    end
                    pub_d = s1_eof_q;
                end
                default: ;
            endcase
        end
    end

    // Stage 2: running best candidate; equal keys keep the earlier pixel.
    cand_t best_q;
    cand_t best_d;
    logic  better;
    logic  pub_q;

    assign better = (s1_cand_q.dark > best_q.dark) ||
                    ((s1_cand_q.dark == best_q.dark) && (s1_cand_q.sum > best_q.sum));

    always_comb begin
        best_d = best_q;
        if (load_best || (cmp_best && better)) begin
            best_d = s1_cand_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= '0;
            pub_q  <= 1'b0;
        end else begin
            best_q <= best_d;
            pub_q  <= pub_d;
        end
    end

    // Publish reads best_q before a back-to-back sof overwrites it on the same edge.
    pix_t ac_r_q;
    pix_t ac_g_q;
    pix_t ac_b_q;
    logic ac_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_r_q     <= AC_RST;
            ac_g_q     <= AC_RST;
            ac_b_q     <= AC_RST;
            ac_valid_q <= 1'b0;
        end else begin
            ac_valid_q <= pub_q;
            if (pub_q) begin
                ac_r_q <= clamp_nz(best_q.r);
                ac_g_q <= clamp_nz(best_q.g);
                ac_b_q <= clamp_nz(best_q.b);
            end
        end
    end

    assign bus.ac_r      = ac_r_q;
    assign bus.ac_g      = ac_g_q;
    assign bus.ac_b      = ac_b_q;
    assign bus.ac_valid  = ac_valid_q;
    assign bus.frame_err = frame_err_w;

endmodule

// File: tb/tb_atmospheric_light_estimator.sv
// Directed-vector bench for atmospheric_light_estimator with hand-computed expected results.
module tb_atmospheric_light_estimator;
    import dehaze_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    atmospheric_light_estimator_if bus_if();

    atmospheric_light_estimator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_err  = 0;
    logic [23:0] pubs[$];

    always @(negedge clk) begin
        if (bus_if.ac_valid) pubs.push_back({bus_if.ac_r, bus_if.ac_g, bus_if.ac_b});
        if (bus_if.frame_err) n_err++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic drive(input logic sof, input logic eof, input int r, input int g, input int b);
        bus_if.in_valid = 1'b1;
        bus_if.in_sof   = sof;
        bus_if.in_eof   = eof;
        bus_if.in_r     = r[7:0];
        bus_if.in_g     = g[7:0];
        bus_if.in_b     = b[7:0];
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_sof   = 1'b0;
        bus_if.in_eof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_ac(input string tag, input int r, input int g, input int b);
        chk({tag, "_r"}, int'(bus_if.ac_r), r);
        chk({tag, "_g"}, int'(bus_if.ac_g), g);
        chk({tag, "_b"}, int'(bus_if.ac_b), b);
    endtask

    // Call right after the eof pixel; ac_valid must rise in the second cycle.
    task automatic wait_pub(input string tag, input int r, input int g, input int b);
        int lat;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.ac_valid && lat == 0) begin
                lat = i;
                chk_ac(tag, r, g, b);
            end
        end
        chk({tag, "_lat"}, lat, 2);
    endtask

    initial begin
        int p0;
        int e0;

        rst             = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_sof   = 1'b0;
        bus_if.in_eof   = 1'b0;
        bus_if.in_r     = '0;
        bus_if.in_g     = '0;
        bus_if.in_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_ac("rst", 255, 255, 255);
        chk("rst_ac_valid", int'(bus_if.ac_valid), 0);
        chk("rst_frame_err", int'(bus_if.frame_err), 0);
        rst = 1'b0;

        p0 = pubs.size();
        e0 = n_err;
        drive(1'b1, 1'b0, 10, 20, 30);
        drive(1'b0, 1'b0, 200, 180, 190);
        drive(1'b0, 1'b0, 50, 60, 70);
        drive(1'b0, 1'b1, 100, 120, 110);
        wait_pub("frame4", 200, 180, 190);
        idle(2);
        chk("frame4_pulses", pubs.size() - p0, 1);
        chk("frame4_errs", n_err - e0, 0);

        drive(1'b1, 1'b0, 100, 120, 130);
        drive(1'b0, 1'b1, 110, 100, 140);
        wait_pub("tie_keep", 100, 120, 130);
        drive(1'b1, 1'b0, 100, 120, 130);
        drive(1'b0, 1'b1, 140, 100, 150);
        wait_pub("tie_sum", 140, 100, 150);

        drive(1'b1, 1'b1, 0, 0, 0);
        wait_pub("clamp0", 1, 1, 1);
        drive(1'b0, 1'b0, 7, 7, 7);
        chk("onepix_stays_idle", int'(bus_if.frame_err), 1);
        idle(2);
        drive(1'b1, 1'b1, 0, 5, 7);
        wait_pub("clamp_r", 1, 5, 7);

        p0 = pubs.size();
        e0 = n_err;
        drive(1'b1, 1'b0, 250, 250, 250);
        drive(1'b0, 1'b0, 200, 210, 220);
        drive(1'b1, 1'b0, 30, 40, 50);
        chk("sof_mid_err", int'(bus_if.frame_err), 1);
        drive(1'b0, 1'b1, 60, 50, 40);
        wait_pub("restart", 60, 50, 40);
        chk("restart_pulses", pubs.size() - p0, 1);
        chk("restart_errs", n_err - e0, 1);

        p0 = pubs.size();
        e0 = n_err;
        drive(1'b0, 1'b1, 9, 9, 9);
        chk("eof_idle_err", int'(bus_if.frame_err), 1);
        idle(5);
        chk_ac("eof_idle_hold", 60, 50, 40);
        chk("eof_idle_pulses", pubs.size() - p0, 0);
        chk("eof_idle_errs", n_err - e0, 1);

        drive(1'b1, 1'b0, 240, 240, 240);
        drive(1'b0, 1'b0, 230, 230, 230);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_ac("rst_mid", 255, 255, 255);
        chk("rst_mid_ac_valid", int'(bus_if.ac_valid), 0);
        rst = 1'b0;

        p0 = pubs.size();
        e0 = n_err;
        drive(1'b1, 1'b0, 5, 6, 7);
        idle(1);
        drive(1'b0, 1'b0, 70, 80, 90);
        drive(1'b0, 1'b1, 1, 2, 3);
        drive(1'b1, 1'b0, 90, 80, 70);
        idle(2);
        drive(1'b0, 1'b1, 20, 200, 20);
        idle(5);
        chk("b2b_pulses", pubs.size() - p0, 2);
        chk("b2b_errs", n_err - e0, 0);
        if (pubs.size() >= p0 + 2) begin
            chk("b2b_first", int'(pubs[p0]), (70 << 16) | (80 << 8) | 90);
            chk("b2b_second", int'(pubs[p0 + 1]), (90 << 16) | (80 << 8) | 70);
        end else begin
            chk("b2b_pubs_present", pubs.size() - p0, 2);
        end
        chk_ac("b2b_final", 90, 80, 70);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
